onchip_mem_avmm_pipelined: RTL and testbench
============================================

Name: onchip_mem_avmm_pipelined

Overview:
Parametrised single-port on-chip RAM with an Avalon-MM pipelined slave interface. It generalises the fixed 16-bit on-chip memory in data width, depth and read latency. It adds readdatavalid/waitrequest handshaking, an optional zero-fill after reset and out-of-range access detection. It sits on the system interconnect as frame-buffer and scratch memory for the video pipeline.

Parameters:
DATA_W, 32, data width in bits; a multiple of 8; byte-lane count BE_W = DATA_W/8.
DEPTH, 15360, number of words.
ADDR_W, 14, word-address width; requires 2^ADDR_W >= DEPTH.
READ_LATENCY, 1, cycles from accepted read to readdatavalid; legal values are 1 and 2.
CLEAR_ON_RESET, 1, when 1, zero-fill all words after reset before accepting traffic.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  ADDR_W  word address
byteenable  in  BE_W  write byte-lane enables
chipselect  in  1  slave select
read  in  1  read request
write  in  1  write request
writedata  in  DATA_W  write data
clken  in  1  clock enable; when low, no new command is accepted
readdata  out  DATA_W  read data
readdatavalid  out  1  readdata is valid this cycle
waitrequest  out  1  command not accepted this cycle
init_done  out  1  high once zero-fill is complete (or immediately, if CLEAR_ON_RESET=0)
oob_err  out  1  sticky: an access to address >= DEPTH has occurred

Behaviour:
- Reset is asynchronous and active-low; it applies while reset_n=0. Output values during and immediately after reset:
  - readdata=0, readdatavalid=0, waitrequest=1, init_done=0, oob_err=0.
  - Read pipeline valid bits are cleared; RAM contents are not reset.
- FSM has two states, CLEAR and READY.
  - Reset entry goes to CLEAR if CLEAR_ON_RESET=1, otherwise to READY.
  - CLEAR: one word per cycle, a write of all zeros with all byte lanes enabled, starting at address 0. Progress ignores clken. waitrequest=1 throughout.
  - After address DEPTH-1 is written, the next state is READY and init_done=1 from that cycle on.
  - Reset asserted mid-CLEAR restarts the fill from address 0.
- READY: waitrequest = ~clken. A command is accepted when chipselect & (read | write) & ~waitrequest.
- Write:
  - The RAM updates at the accepting clock edge; only lanes with byteenable=1 change.
  - byteenable=0 on a write is a no-op and still counts as accepted.
  - A read accepted in the next cycle at the same address returns the new data.
- Read:
  - readdatavalid pulses exactly READ_LATENCY cycles after acceptance, with matching readdata.
  - Back-to-back reads are accepted every cycle; responses return in order, one per cycle.
  - In-flight reads always complete, even if clken drops.
  - readdata holds its last value when readdatavalid=0.
- read and write both high in the same accepted cycle: the write is performed, and no readdatavalid is produced for it.
- address >= DEPTH:
  - Write: dropped.
  - Read: returns 0 with a normal readdatavalid.
  - Either access sets oob_err, which is cleared only by reset.
- chipselect=0: read and write are ignored and no response is produced.
- Address arithmetic in CLEAR: the counter is ADDR_W wide and compares against DEPTH-1, with no wrap beyond DEPTH.

Decomposition:
- Shared package onchip_mem_pkg holds:
  - the state enum (CLEAR, READY);
  - the legal READ_LATENCY constants;
  - a clog2 helper used for ADDR_W checks.
- One sub-module, onchip_ram_sp: an inferred single-port byte-enabled RAM (DATA_W, DEPTH) with a synchronous registered read and no reset.
- The top level holds the FSM, the clear counter, the READY/CLEAR mux onto the RAM port, the range check and the readdatavalid shift pipeline, plus the optional output register when READ_LATENCY=2.

Test Plan:
1. Zero-fill: defaults, release reset_n → waitrequest=1 and init_done=0 for 15360 cycles, then init_done=1 and waitrequest=0; a read of addr 0x1234 returns 0x00000000.
2. Byte enables: write 0xAABBCCDD to addr 5 with byteenable 4'b1111, then write 0x11223344 with byteenable 4'b0101 → a read of addr 5 returns 0xAA22CC44, with readdatavalid exactly 1 cycle after acceptance.
3. Pipelined reads, READ_LATENCY=2: write addr k = k for k=0..3, then issue 4 back-to-back reads of addrs 0..3 → readdatavalid high for 4 consecutive cycles starting 2 cycles after the first acceptance, with data 0,1,2,3 in order.
4. Out-of-range: write 0xDEADBEEF to addr 15360 and then read addr 15360 → read returns 0, oob_err=1 and stays 1; a read of addr 0 is unaffected.
5. clken/handshake: drop clken during a read stream → waitrequest=1 that cycle, the pending read still completes with readdatavalid, and no command is accepted until clken=1.
6. Reset mid-clear: assert reset_n=0 at clear cycle 8000 and release → init_done rises 15360 cycles after the second release.

Source files
------------

// File: rtl/onchip_mem_pkg.sv
// Shared types and constants for the Avalon-MM pipelined on-chip RAM.
// Imported by the RAM macro wrapper and the slave top level.
package onchip_mem_pkg;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  localparam int RL_MIN = 1;
  localparam int RL_MAX = 2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1)
      r++;
    return r;
  endfunction

endpackage

// File: rtl/onchip_ram_sp.sv
// Inferred single-port byte-enabled RAM.
// Registered read output, no reset on the array or the output.
module onchip_ram_sp
  import onchip_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 15360,
  parameter int ADDR_W = 14,
  localparam int BE_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [BE_W-1:0]   be,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i])
          mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    if (re)
      rdata <= mem[addr];
  end

endmodule

// File: rtl/onchip_mem_avmm_pipelined.sv
// Avalon-MM pipelined slave around a single-port RAM, with optional
// zero-fill after reset and sticky out-of-range detection.
module onchip_mem_avmm_pipelined
  import onchip_mem_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 15360,
  parameter int ADDR_W         = 14,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1,
  localparam int BE_W          = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic [BE_W-1:0]   byteenable,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  input  logic              clken,
  output logic [DATA_W-1:0] readdata,
  output logic              readdatavalid,
  output logic              waitrequest,
  output logic              init_done,
  output logic              oob_err
);

  if (clog2(DEPTH) > ADDR_W ||
      (READ_LATENCY != RL_MIN &&
       READ_LATENCY != RL_MAX)) begin : g_bad
    $error("illegal ADDR_W or READ_LATENCY");
  end

  localparam logic [ADDR_W:0] DEPTH_X =
    (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] clr_addr;
  logic              in_range;
  logic              acc;
  logic              rd_req;
  logic              ram_we;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [BE_W-1:0]   ram_be;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] stage1;
  logic              v1;
  logic              rd_oob;
  logic              has_data;

  assign in_range    = {1'b0, address} < DEPTH_X;
  assign waitrequest = ~init_done | ~clken;
  assign acc    = chipselect & (read | write) &
                  ~waitrequest & (state == READY);
  assign rd_req = acc & read & ~write;

  // CLEAR owns the RAM port; traffic only reaches it in READY
  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = address;
    ram_be    = byteenable;
    ram_wdata = writedata;
    if (state == CLEAR) begin
      ram_we    = 1'b1;
      ram_addr  = clr_addr;
      ram_be    = '1;
      ram_wdata = '0;
    end else begin
      ram_we = acc & write & in_range;
      ram_re = rd_req & in_range;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      clr_addr  <= '0;
      init_done <= 1'b0;
      oob_err   <= 1'b0;
    end else begin
      unique case (state)
        CLEAR: begin
          if (clr_addr == LAST) begin
            state     <= READY;
            init_done <= 1'b1;
          end else begin
            clr_addr <= clr_addr + ADDR_W'(1);
          end
        end
        READY: begin
          init_done <= 1'b1;
          if (acc & ~in_range)
            oob_err <= 1'b1;
        end
      endcase
    end
  end

  onchip_ram_sp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .be    (ram_be),
    .wdata (ram_wdata),
    .rdata (ram_q)
  );

  // ram_q is unreset; mask it until a read has landed or if it was OOB
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1       <= 1'b0;
      rd_oob   <= 1'b0;
      has_data <= 1'b0;
    end else begin
      v1 <= rd_req;
      if (rd_req) begin
        rd_oob   <= ~in_range;
        has_data <= 1'b1;
      end
    end
  end

  assign stage1 = (has_data & ~rd_oob) ? ram_q : '0;

  if (READ_LATENCY == RL_MAX) begin : g_lat2
    logic              v2;
    logic [DATA_W-1:0] q2;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        v2 <= 1'b0;
        q2 <= '0;
      end else begin
        v2 <= v1;
        if (v1)
          q2 <= stage1;
      end
    end
    assign readdatavalid = v2;
    assign readdata      = q2;
  end else begin : g_lat1
    assign readdatavalid = v1;
    assign readdata      = stage1;
  end

endmodule

// File: tb/tb_onchip_mem_avmm_pipelined.sv
// Self-checking bench: default instance plus a small latency-2 instance,
// directed scenarios and a randomized run against a reference model.
module tb_onchip_mem_avmm_pipelined;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [13:0] address;
  logic [3:0]  be;
  logic        cs1, cs2, rd, wr, clken;
  logic [31:0] wdata;

  logic [31:0] rdata1, rdata2;
  logic        rdv1, rdv2, wait1, wait2;
  logic        done1, done2, oob1, oob2;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem_m [16];

  typedef struct {
    logic [31:0] d;
    int          due;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  onchip_mem_avmm_pipelined u_dut1 (
    .clk           (clk),
    .reset_n       (reset_n),
    .address       (address),
    .byteenable    (be),
    .chipselect    (cs1),
    .read          (rd),
    .write         (wr),
    .writedata     (wdata),
    .clken         (clken),
    .readdata      (rdata1),
    .readdatavalid (rdv1),
    .waitrequest   (wait1),
    .init_done     (done1),
    .oob_err       (oob1)
  );

  onchip_mem_avmm_pipelined #(
    .DATA_W         (32),
    .DEPTH          (100),
    .ADDR_W         (7),
    .READ_LATENCY   (2),
    .CLEAR_ON_RESET (1)
  ) u_dut2 (
    .clk           (clk),
    .reset_n       (reset_n),
    .address       (address[6:0]),
    .byteenable    (be),
    .chipselect    (cs2),
    .read          (rd),
    .write         (wr),
    .writedata     (wdata),
    .clken         (clken),
    .readdata      (rdata2),
    .readdatavalid (rdv2),
    .waitrequest   (wait2),
    .init_done     (done2),
    .oob_err       (oob2)
  );

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] nw,
    input logic [3:0]  b
  );
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (b[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  task automatic drive(
    input logic c1, input logic c2,
    input logic r, input logic w,
    input logic ce, input logic [13:0] a,
    input logic [3:0] b, input logic [31:0] d
  );
    cs1 = c1; cs2 = c2; rd = r; wr = w;
    clken = ce; address = a; be = b; wdata = d;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 1, 14'd0, 4'd0, 32'd0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle();
    repeat (3) @(negedge clk);
    checks++;
    if (rdata1 !== 32'd0) begin
      errors++; $display("FAIL reset_readdata got %h exp 0", rdata1);
    end
    checks++;
    if (rdv1 !== 1'b0 || rdv2 !== 1'b0) begin
      errors++; $display("FAIL reset_rdv got %b/%b exp 0", rdv1, rdv2);
    end
    checks++;
    if (wait1 !== 1'b1 || wait2 !== 1'b1) begin
      errors++; $display("FAIL reset_wait got %b/%b exp 1", wait1, wait2);
    end
    checks++;
    if (done1 !== 1'b0 || oob1 !== 1'b0) begin
      errors++; $display("FAIL reset_flags done=%b oob=%b exp 0/0", done1, oob1);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_zero_fill();
    int  n;
    bit  wr_ok;
    n = 0;
    wr_ok = 1'b1;
    for (int i = 0; i < 16; i++) mem_m[i] = 32'd0;
    while (done1 !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
      if (done1 !== 1'b1 && wait1 !== 1'b1) wr_ok = 1'b0;
    end
    checks++;
    if (n != 15360) begin
      errors++; $display("FAIL fill_cycles got %0d exp 15360", n);
    end
    checks++;
    if (!wr_ok) begin
      errors++; $display("FAIL fill_wait got 0 during clear exp 1");
    end
    checks++;
    if (wait1 !== 1'b0) begin
      errors++; $display("FAIL fill_ready_wait got %b exp 0", wait1);
    end
    drive(1, 0, 1, 0, 1, 14'h1234, 4'h0, 32'd0);
    @(negedge clk);
    idle();
    checks++;
    if (rdv1 !== 1'b1 || rdata1 !== 32'd0) begin
      errors++; $display("FAIL fill_read v=%b d=%h exp 1/0", rdv1, rdata1);
    end
  endtask

  task automatic test_byte_enables();
    @(negedge clk);
    drive(1, 0, 0, 1, 1, 14'd5, 4'hF, 32'hAABBCCDD);
    mem_m[5] = merge(mem_m[5], 32'hAABBCCDD, 4'hF);
    @(negedge clk);
    drive(1, 0, 0, 1, 1, 14'd5, 4'b0101, 32'h11223344);
    mem_m[5] = merge(mem_m[5], 32'h11223344, 4'b0101);
    @(negedge clk);
    drive(1, 0, 1, 0, 1, 14'd5, 4'h0, 32'd0);
    @(negedge clk);
    idle();
    checks++;
    if (rdv1 !== 1'b1 || rdata1 !== 32'hAA22CC44) begin
      errors++; $display("FAIL be_read v=%b d=%h exp 1/aa22cc44", rdv1, rdata1);
    end
    @(negedge clk);
    checks++;
    if (rdv1 !== 1'b0 || rdata1 !== 32'hAA22CC44) begin
      errors++; $display("FAIL be_hold v=%b d=%h exp 0/aa22cc44", rdv1, rdata1);
    end
  endtask

  task automatic test_pipelined();
    logic exp_v;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(0, 1, 0, 1, 1, 14'(k), 4'hF, 32'(k));
    end
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      exp_v = (n >= 2 && n <= 5);
      checks++;
      if (rdv2 !== exp_v || (exp_v && rdata2 !== 32'(n - 2))) begin
        errors++;
        $display("FAIL pipe_n%0d v=%b d=%h exp %b/%h",
                 n, rdv2, rdata2, exp_v, 32'(n - 2));
      end
      if (n < 4) drive(0, 1, 1, 0, 1, 14'(n), 4'h0, 32'd0);
      else idle();
    end
  endtask

  task automatic test_out_of_range();
    @(negedge clk);
    drive(1, 0, 0, 1, 1, 14'd15360, 4'hF, 32'hDEADBEEF);
    @(negedge clk);
    drive(1, 0, 1, 0, 1, 14'd15360, 4'h0, 32'd0);
    checks++;
    if (oob1 !== 1'b1) begin
      errors++; $display("FAIL oob_set got %b exp 1", oob1);
    end
    @(negedge clk);
    idle();
    checks++;
    if (rdv1 !== 1'b1 || rdata1 !== 32'd0) begin
      errors++; $display("FAIL oob_read v=%b d=%h exp 1/0", rdv1, rdata1);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (oob1 !== 1'b1) begin
      errors++; $display("FAIL oob_sticky got %b exp 1", oob1);
    end
    drive(1, 0, 1, 0, 1, 14'd0, 4'h0, 32'd0);
    @(negedge clk);
    idle();
    checks++;
    if (rdv1 !== 1'b1 || rdata1 !== mem_m[0]) begin
      errors++; $display("FAIL oob_addr0 v=%b d=%h exp 1/%h", rdv1, rdata1, mem_m[0]);
    end
    checks++;
    if (oob2 !== 1'b0) begin
      errors++; $display("FAIL oob2_clear got %b exp 0", oob2);
    end
    drive(0, 1, 0, 1, 1, 14'd100, 4'hF, 32'h12345678);
    @(negedge clk);
    idle();
    @(negedge clk);
    checks++;
    if (oob2 !== 1'b1) begin
      errors++; $display("FAIL oob2_set got %b exp 1", oob2);
    end
  endtask

  task automatic test_clken();
    @(negedge clk);
    drive(0, 1, 1, 0, 1, 14'd2, 4'h0, 32'd0);
    @(negedge clk);
    drive(0, 1, 1, 0, 0, 14'd3, 4'h0, 32'd0);
    #1;
    checks++;
    if (wait2 !== 1'b1) begin
      errors++; $display("FAIL clken_wait got %b exp 1", wait2);
    end
    @(negedge clk);
    checks++;
    if (rdv2 !== 1'b1 || rdata2 !== 32'd2) begin
      errors++; $display("FAIL clken_inflight v=%b d=%h exp 1/2", rdv2, rdata2);
    end
    @(negedge clk);
    checks++;
    if (rdv2 !== 1'b0) begin
      errors++; $display("FAIL clken_blocked got %b exp 0", rdv2);
    end
    clken = 1'b1;
    @(negedge clk);
    idle();
    checks++;
    if (rdv2 !== 1'b0) begin
      errors++; $display("FAIL clken_gap got %b exp 0", rdv2);
    end
    @(negedge clk);
    checks++;
    if (rdv2 !== 1'b1 || rdata2 !== 32'd3) begin
      errors++; $display("FAIL clken_resume v=%b d=%h exp 1/3", rdv2, rdata2);
    end
    @(negedge clk);
    checks++;
    if (rdv2 !== 1'b0) begin
      errors++; $display("FAIL clken_single got %b exp 0", rdv2);
    end
  endtask

  task automatic test_random();
    int          cyc;
    logic [31:0] last;
    bit          have_last;
    logic        c1, r, w, ce, inr;
    logic [13:0] a;
    logic [3:0]  b;
    logic [31:0] d;
    exp_t        e;
    cyc = 0;
    have_last = 1'b0;
    last = 32'd0;
    q.delete();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      cyc++;
      checks++;
      if (q.size() > 0 && q[0].due == cyc) begin
        if (rdv1 !== 1'b1 || rdata1 !== q[0].d) begin
          errors++;
          $display("FAIL rand_resp c%0d v=%b d=%h exp 1/%h",
                   cyc, rdv1, rdata1, q[0].d);
        end
        last = q[0].d;
        have_last = 1'b1;
        void'(q.pop_front());
      end else begin
        if (rdv1 !== 1'b0 || (have_last && rdata1 !== last)) begin
          errors++;
          $display("FAIL rand_idle c%0d v=%b d=%h exp 0/%h",
                   cyc, rdv1, rdata1, last);
        end
      end
      if (i < 390) begin
        c1 = ($urandom_range(0, 7) != 0);
        r  = 1'($urandom_range(0, 1));
        w  = ($urandom_range(0, 2) == 0);
        ce = ($urandom_range(0, 4) != 0);
        a  = ($urandom_range(0, 9) == 0) ?
             14'(15360 + $urandom_range(0, 3)) :
             14'($urandom_range(0, 15));
        b  = 4'($urandom);
        d  = $urandom;
      end else begin
        c1 = 0; r = 0; w = 0; ce = 1;
        a = 14'd0; b = 4'd0; d = 32'd0;
      end
      drive(c1, 0, r, w, ce, a, b, d);
      #1;
      checks++;
      if (wait1 !== ~ce) begin
        errors++; $display("FAIL rand_wait c%0d got %b exp %b", cyc, wait1, ~ce);
      end
      inr = (a < 14'd15360);
      if (c1 && (r || w) && ce) begin
        if (w && inr)
          mem_m[a[3:0]] = merge(mem_m[a[3:0]], d, b);
        if (r && !w) begin
          e.d = inr ? mem_m[a[3:0]] : 32'd0;
          e.due = cyc + 1;
          q.push_back(e);
        end
      end
    end
    checks++;
    if (q.size() != 0) begin
      errors++; $display("FAIL rand_drain got %0d pending exp 0", q.size());
    end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    @(negedge clk);
    reset_n = 1'b0;
    idle();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8000) @(negedge clk);
    checks++;
    if (done1 !== 1'b0) begin
      errors++; $display("FAIL mid_done got %b exp 0", done1);
    end
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (oob1 !== 1'b0 || wait1 !== 1'b1 || rdata1 !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset oob=%b wait=%b d=%h exp 0/1/0", oob1, wait1, rdata1);
    end
    reset_n = 1'b1;
    n = 0;
    while (done1 !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 15360) begin
      errors++; $display("FAIL mid_cycles got %0d exp 15360", n);
    end
    drive(1, 0, 1, 0, 1, 14'd5, 4'h0, 32'd0);
    @(negedge clk);
    idle();
    checks++;
    if (rdv1 !== 1'b1 || rdata1 !== 32'd0) begin
      errors++; $display("FAIL mid_refill v=%b d=%h exp 1/0", rdv1, rdata1);
    end
  endtask

  initial begin
    test_reset();
    test_zero_fill();
    test_byte_enables();
    test_pipelined();
    test_out_of_range();
    test_clken();
    test_random();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
